osd_mam_req_arbiter: RTL and testbench
======================================

Name: osd_mam_req_arbiter

Overview:
- Shares one MAM memory-access port, the req/write/read stream interface of the Wishbone MAM adapter, between NUM_REQ requesters.
- Typical requesters are the debug MAM and a trace/DMA agent.
- Grants one requester per transaction using round-robin order, then routes that requester's write and read streams until the last beat completes.
- Sits between the requesters and the single downstream memory-interface adapter.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 16, data bits per beat; must be a multiple of 16.
- ADDR_WIDTH, 32, address bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- s_req_valid  in  NUM_REQ  per-requester request valid.
- s_req_ready  out  NUM_REQ  per-requester request accept.
- s_req_rw  in  NUM_REQ  per-requester direction; 1 = write.
- s_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened base addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_req_burst  in  NUM_REQ  per-requester burst flag.
- s_req_beats  in  NUM_REQ*14  flattened burst lengths.
- s_write_valid  in  NUM_REQ  per-requester write data valid.
- s_write_data  in  NUM_REQ*DATA_WIDTH  flattened write data.
- s_write_strb  in  NUM_REQ*DATA_WIDTH/8  flattened byte strobes.
- s_write_ready  out  NUM_REQ  per-requester write accept.
- s_read_valid  out  NUM_REQ  per-requester read data valid.
- s_read_data  out  DATA_WIDTH  read data, broadcast to all requesters.
- s_read_ready  in  NUM_REQ  per-requester read accept.
- m_req_valid, m_req_rw, m_req_burst  out  1 each  downstream request fields.
- m_req_addr  out  ADDR_WIDTH  downstream base address.
- m_req_beats  out  14  downstream burst length.
- m_req_ready  in  1  downstream request accept.
- m_write_valid  out  1  downstream write valid.
- m_write_data  out  DATA_WIDTH  downstream write data.
- m_write_strb  out  DATA_WIDTH/8  downstream byte strobes.
- m_write_ready  in  1  downstream write accept.
- m_read_valid  in  1  downstream read valid.
- m_read_data  in  DATA_WIDTH  downstream read data.
- m_read_ready  out  1  downstream read accept.
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, grant_o=0, busy_o=0, round-robin pointer=0, beat counter=0.
- While in IDLE (including from reset), all s_*_ready, s_read_valid, m_req_valid, m_write_valid and m_read_ready are 0.
- Registered state: state, grant, pointer, beat counter, latched rw.
- Routing is purely combinational from the registered grant.
- State machine:
  - IDLE: if any s_req_valid is set, register the grant to the first requester at or after the pointer (cyclic search); go to REQ. Latency is 1 cycle from s_req_valid to m_req_valid.
  - REQ: m_req_* = granted s_req_*, and s_req_ready[g] = m_req_ready. On the handshake, latch rw and load count = burst ? beats : 1, with beats==0 treated as 1. Go to WR if rw=1, else RD. Pointer becomes g+1 mod NUM_REQ.
  - WR: m_write_* = granted s_write_*, and s_write_ready[g] = m_write_ready. Decrement count on each m_write handshake; on the handshake with count==1, clear the grant and go to IDLE.
  - RD: s_read_valid[g] = m_read_valid, and m_read_ready = s_read_ready[g]. Decrement count on each handshake; the last one returns to IDLE.
- Non-granted requesters always see ready=0 and read_valid=0. A requester that deasserts s_req_valid in REQ is not a legal stimulus; the arbiter holds the grant.
- A new grant cannot be issued in the cycle the last beat completes. There is always at least one IDLE cycle between transactions.
- Fairness: a requester that keeps s_req_valid asserted is granted within NUM_REQ transactions.
- When several requesters assert s_req_valid simultaneously, only the pointer decides priority.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops all valids and readies. The downstream adapter must be reset in the same domain.

Decomposition:
- Package osd_mam_arb_pkg holds the state enum (IDLE, REQ, WR, RD) and the BEATS_W=14 constant.
- Sub-module osd_rr_arbiter (purely combinational): inputs req vector and pointer; output one-hot grant.

Test Plan:
- Single write from requester 0, burst=0, addr 0x100, data 0xBEEF, with m_*_ready held 1:
  - grant_o=01 one cycle after s_req_valid.
  - m_req_addr=0x100, m_write_data=0xBEEF.
  - Back to IDLE after 1 write handshake.
- Both requesters assert read bursts of 4 at the same time:
  - Requester 0 is served first; exactly 4 read handshakes route to requester 0.
  - Then requester 1 is served; s_read_valid[1] stays 0 throughout requester 0's burst.
- Requester 1 write burst of 3 with s_write_valid gapped, and m_write_ready toggled every cycle:
  - Exactly 3 handshakes occur; busy_o falls the cycle after the third.
- Requester 0 continuously requests while requester 1 requests once:
  - Requester 1 is granted on the second transaction, proving round-robin order.
- Burst with beats=0: completes after 1 beat and returns to IDLE.
- rst_i asserted during the 2nd beat of a 4-beat read:
  - All outputs go to their reset values asynchronously.
  - After release, a new request from requester 1 is granted normally.

Source files
------------

// File: rtl/osd_mam_arb_pkg.sv
// Shared types and constants for the MAM request arbiter.
package osd_mam_arb_pkg;

    localparam int BEATS_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WR,
        RD
    } state_t;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, searching cyclically.
module osd_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_mam_req_arbiter.sv
// Shares one MAM req/write/read port between NUM_REQ requesters, one transaction
// at a time, in round-robin order.
module osd_mam_req_arbiter
    import osd_mam_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    input  logic [NUM_REQ-1:0]             s_req_valid,
    output logic [NUM_REQ-1:0]             s_req_ready,
    input  logic [NUM_REQ-1:0]             s_req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_req_addr,
    input  logic [NUM_REQ-1:0]             s_req_burst,
    input  logic [NUM_REQ*BEATS_W-1:0]     s_req_beats,
    input  logic [NUM_REQ-1:0]             s_write_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_write_data,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_write_strb,
    output logic [NUM_REQ-1:0]             s_write_ready,
    output logic [NUM_REQ-1:0]             s_read_valid,
    output logic [DATA_WIDTH-1:0]          s_read_data,
    input  logic [NUM_REQ-1:0]             s_read_ready,

    output logic                           m_req_valid,
    output logic                           m_req_rw,
    output logic                           m_req_burst,
    output logic [ADDR_WIDTH-1:0]          m_req_addr,
    output logic [BEATS_W-1:0]             m_req_beats,
    input  logic                           m_req_ready,
    output logic                           m_write_valid,
    output logic [DATA_WIDTH-1:0]          m_write_data,
    output logic [DATA_WIDTH/8-1:0]        m_write_strb,
    input  logic                           m_write_ready,
    input  logic                           m_read_valid,
    input  logic [DATA_WIDTH-1:0]          m_read_data,
    output logic                           m_read_ready,

    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [BEATS_W-1:0]   count_q, count_d;
    logic                 rw_q, rw_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     gidx;
    logic                 req_hs;
    logic                 beat_hs;

    osd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (s_req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) gidx = PTR_W'(i);
        end
    end

    assign s_read_data = m_read_data;

    // Data fields always follow the owner; only valids and readies are gated by state.
    always_comb begin
        s_req_ready   = '0;
        s_write_ready = '0;
        s_read_valid  = '0;
        m_req_valid   = 1'b0;
        m_write_valid = 1'b0;
        m_read_ready  = 1'b0;
        m_req_rw      = s_req_rw[gidx];
        m_req_burst   = s_req_burst[gidx];
        m_req_addr    = s_req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        m_req_beats   = s_req_beats[int'(gidx)*BEATS_W +: BEATS_W];
        m_write_data  = s_write_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        m_write_strb  = s_write_strb[int'(gidx)*STRB_W +: STRB_W];
        unique case (state_q)
            REQ: begin
                m_req_valid       = s_req_valid[gidx];
                s_req_ready[gidx] = m_req_ready;
            end
            WR: begin
                m_write_valid       = s_write_valid[gidx];
                s_write_ready[gidx] = m_write_ready;
            end
            RD: begin
                s_read_valid[gidx] = m_read_valid;
                m_read_ready       = s_read_ready[gidx];
            end
            default: ;
        endcase
    end

    assign req_hs  = m_req_valid & m_req_ready;
    assign beat_hs = rw_q ? (m_write_valid & m_write_ready) : (m_read_valid & m_read_ready);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        rw_d    = rw_q;
        unique case (state_q)
            IDLE: begin
                if (|s_req_valid) begin
                    grant_d = arb_grant;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    rw_d    = m_req_rw;
                    ptr_d   = PTR_W'((int'(gidx) + 1) % NUM_REQ);
                    state_d = m_req_rw ? WR : RD;
                    // A zero-length burst still moves one beat.
                    if (!m_req_burst || m_req_beats == '0) count_d = BEATS_W'(1);
                    else                                    count_d = m_req_beats;
                end
            end
            WR, RD: begin
                if (beat_hs) begin
                    count_d = count_q - BEATS_W'(1);
                    if (count_q == BEATS_W'(1)) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            rw_q    <= rw_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_osd_mam_req_arbiter.sv
// Self-checking bench: transaction-level reference model, directed scenarios, random traffic.
`timescale 1ns/1ps
module tb_osd_mam_req_arbiter;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int BW = 14;
    localparam int SW = DW / 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      s_req_valid, s_req_ready, s_req_rw, s_req_burst;
    logic [N*AW-1:0]   s_req_addr;
    logic [N*BW-1:0]   s_req_beats;
    logic [N-1:0]      s_write_valid, s_write_ready;
    logic [N*DW-1:0]   s_write_data;
    logic [N*SW-1:0]   s_write_strb;
    logic [N-1:0]      s_read_valid, s_read_ready;
    logic [DW-1:0]     s_read_data;
    logic              m_req_valid, m_req_rw, m_req_burst, m_req_ready;
    logic [AW-1:0]     m_req_addr;
    logic [BW-1:0]     m_req_beats;
    logic              m_write_valid, m_write_ready;
    logic [DW-1:0]     m_write_data;
    logic [SW-1:0]     m_write_strb;
    logic              m_read_valid, m_read_ready;
    logic [DW-1:0]     m_read_data;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    osd_mam_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
        .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
        .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_write_strb(s_write_strb),
        .s_write_ready(s_write_ready), .s_read_valid(s_read_valid), .s_read_data(s_read_data),
        .s_read_ready(s_read_ready),
        .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_burst(m_req_burst),
        .m_req_addr(m_req_addr), .m_req_beats(m_req_beats), .m_req_ready(m_req_ready),
        .m_write_valid(m_write_valid), .m_write_data(m_write_data), .m_write_strb(m_write_strb),
        .m_write_ready(m_write_ready), .m_read_valid(m_read_valid), .m_read_data(m_read_data),
        .m_read_ready(m_read_ready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // ---------------- reference model: who owns the port, which phase, beats left
    int mdl_owner   = -1;
    bit mdl_in_req  = 1'b0;
    bit mdl_write   = 1'b0;
    int mdl_left    = 0;
    int mdl_ptr     = 0;
    int wait_txn[N];
    int mc;
    int mbeats;
    bit mhs;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdl_owner  = -1;
            mdl_in_req = 1'b0;
            mdl_left   = 0;
            mdl_ptr    = 0;
            for (int j = 0; j < N; j++) wait_txn[j] = 0;
        end else if (mdl_owner < 0) begin
            if (s_req_valid != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    mc = (mdl_ptr + k) % N;
                    if (bit_at(s_req_valid, mc)) mdl_owner = mc;
                end
                mdl_in_req = 1'b1;
                check("fairness_bound", 64'(wait_txn[mdl_owner] < N), 64'd1);
                for (int j = 0; j < N; j++)
                    if (j != mdl_owner && bit_at(s_req_valid, j)) wait_txn[j]++;
                wait_txn[mdl_owner] = 0;
            end
        end else if (mdl_in_req) begin
            if (bit_at(s_req_valid, mdl_owner) && m_req_ready) begin
                mdl_in_req = 1'b0;
                mdl_write  = bit_at(s_req_rw, mdl_owner);
                mbeats     = int'(BW'(s_req_beats >> (mdl_owner * BW)));
                mdl_left   = (bit_at(s_req_burst, mdl_owner) && mbeats != 0) ? mbeats : 1;
                mdl_ptr    = (mdl_owner + 1) % N;
            end
        end else begin
            mhs = mdl_write ? (bit_at(s_write_valid, mdl_owner) && m_write_ready)
                            : (m_read_valid && bit_at(s_read_ready, mdl_owner));
            if (mhs) begin
                mdl_left--;
                if (mdl_left == 0) mdl_owner = -1;
            end
        end
    end

    // ---------------- per-cycle comparison against the model
    logic [N-1:0] e_vec;
    bit ph_wr, ph_rd;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            ph_wr = (mdl_owner >= 0) && !mdl_in_req && mdl_write;
            ph_rd = (mdl_owner >= 0) && !mdl_in_req && !mdl_write;
            e_vec = (mdl_owner >= 0) ? (N'(1) << mdl_owner) : '0;
            check("grant_o", 64'(grant_o), 64'(e_vec));
            check("busy_o", 64'(busy_o), 64'(mdl_owner >= 0));
            check("s_req_ready", 64'(s_req_ready), 64'((mdl_in_req && m_req_ready) ? e_vec : '0));
            check("m_req_valid", 64'(m_req_valid), 64'(mdl_in_req && bit_at(s_req_valid, mdl_owner)));
            if (mdl_in_req) begin
                check("m_req_addr", 64'(m_req_addr), 64'(AW'(s_req_addr >> (mdl_owner * AW))));
                check("m_req_rw", 64'(m_req_rw), 64'(bit_at(s_req_rw, mdl_owner)));
                check("m_req_burst", 64'(m_req_burst), 64'(bit_at(s_req_burst, mdl_owner)));
                check("m_req_beats", 64'(m_req_beats), 64'(BW'(s_req_beats >> (mdl_owner * BW))));
            end
            check("m_write_valid", 64'(m_write_valid), 64'(ph_wr && bit_at(s_write_valid, mdl_owner)));
            check("s_write_ready", 64'(s_write_ready), 64'((ph_wr && m_write_ready) ? e_vec : '0));
            if (ph_wr) begin
                check("m_write_data", 64'(m_write_data), 64'(DW'(s_write_data >> (mdl_owner * DW))));
                check("m_write_strb", 64'(m_write_strb), 64'(SW'(s_write_strb >> (mdl_owner * SW))));
            end
            check("s_read_valid", 64'(s_read_valid), 64'((ph_rd && m_read_valid) ? e_vec : '0));
            check("m_read_ready", 64'(m_read_ready), 64'(ph_rd && bit_at(s_read_ready, mdl_owner)));
            check("s_read_data", 64'(s_read_data), 64'(m_read_data));
        end
    end

    // ---------------- transaction monitor for the directed scenarios
    logic [N-1:0] req_hs_last = '0;
    logic [N-1:0] hold_req    = '0;
    int wr_cnt[N];
    int rd_cnt[N];
    int gq[$];
    int cyc = 0;
    int leak1, wr3_cyc, busy_fall_cyc;
    bit was_busy;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (rst_i) begin
            req_hs_last = '0;
        end else begin
            req_hs_last = s_req_valid & s_req_ready;
            for (int i = 0; i < N; i++) begin
                if (bit_at(req_hs_last, i)) gq.push_back(i);
                if (bit_at(s_write_valid & s_write_ready, i)) begin
                    wr_cnt[i]++;
                    if (i == 1 && wr_cnt[i] == 3) wr3_cyc = cyc;
                end
                if (bit_at(s_read_valid & s_read_ready, i)) rd_cnt[i]++;
            end
            if (grant_o[0] && s_read_valid[1]) leak1++;
            if (was_busy && !busy_o && busy_fall_cyc < 0) busy_fall_cyc = cyc;
            was_busy = busy_o;
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0;
            rd_cnt[i] = 0;
        end
        gq.delete();
        leak1         = 0;
        wr3_cyc       = -1;
        busy_fall_cyc = -1;
        was_busy      = 1'b0;
    endtask

    task automatic idle_inputs();
        s_req_valid   = '0;  s_req_rw = '0;  s_req_burst = '0;
        s_req_addr    = '0;  s_req_beats = '0;
        s_write_valid = '0;  s_write_data = '0;  s_write_strb = '0;
        s_read_ready  = '0;
        m_req_ready   = 1'b0;  m_write_ready = 1'b0;
        m_read_valid  = 1'b0;  m_read_data = '0;
        hold_req      = '0;
    endtask

    // One clock; requesters withdraw a request once it has been accepted.
    task automatic step();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++)
            if (bit_at(req_hs_last, i) && !bit_at(hold_req, i)) s_req_valid[i] = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((busy_o || s_req_valid != '0) && k < budget);
        check({name, "_done"}, 64'(busy_o || s_req_valid != '0), 64'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valids", 64'({m_req_valid, m_write_valid, m_read_ready, s_read_valid}), 64'd0);
        check("rst_readies", 64'({s_req_ready, s_write_ready}), 64'd0);
        rst_i = 1'b0;
        step();
        clear_stats();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        clear_stats();

        // Single write from requester 0
        do_reset();
        s_req_rw[0] = 1'b1;
        s_req_addr[0 +: AW] = 32'h100;
        s_write_valid[0] = 1'b1;
        s_write_data[0 +: DW] = 16'hBEEF;
        s_write_strb[0 +: SW] = 2'b11;
        m_req_ready = 1'b1;  m_write_ready = 1'b1;
        s_req_valid[0] = 1'b1;
        step();
        check("t1_grant", 64'(grant_o), 64'h1);
        check("t1_addr", 64'(m_req_addr), 64'h100);
        step();
        check("t1_wvalid", 64'(m_write_valid), 64'd1);
        check("t1_wdata", 64'(m_write_data), 64'hBEEF);
        step();
        check("t1_idle", 64'(busy_o), 64'd0);
        check("t1_wr_cnt", 64'(wr_cnt[0]), 64'd1);
        s_write_valid = '0;

        // Simultaneous 4-beat reads
        do_reset();
        s_req_burst = 2'b11;
        s_req_beats = {14'd4, 14'd4};
        m_req_ready = 1'b1;  m_read_valid = 1'b1;  m_read_data = 16'h1234;
        s_read_ready = 2'b11;
        s_req_valid = 2'b11;
        run_until_idle("t2", 60);
        check("t2_txn_count", 64'(gq.size()), 64'd2);
        check("t2_first", 64'(gq.size() > 0 ? gq[0] : -1), 64'd0);
        check("t2_second", 64'(gq.size() > 1 ? gq[1] : -1), 64'd1);
        check("t2_rd0", 64'(rd_cnt[0]), 64'd4);
        check("t2_rd1", 64'(rd_cnt[1]), 64'd4);
        check("t2_no_leak", 64'(leak1), 64'd0);

        // Gapped 3-beat write from requester 1 with toggling downstream ready
        do_reset();
        s_req_rw[1] = 1'b1;  s_req_burst[1] = 1'b1;
        s_req_beats[BW +: BW] = 14'd3;
        s_write_data[DW +: DW] = 16'hA5A5;
        s_write_strb[SW +: SW] = 2'b10;
        m_req_ready = 1'b1;
        s_req_valid[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            m_write_ready = ~m_write_ready;
            s_write_valid[1] = (k % 3 != 1);
        end
        check("t3_wr_cnt", 64'(wr_cnt[1]), 64'd3);
        check("t3_busy_fall", 64'(busy_fall_cyc - wr3_cyc), 64'd1);
        check("t3_idle", 64'(busy_o), 64'd0);
        s_write_valid = '0;

        // Requester 0 requests continuously, requester 1 once
        do_reset();
        m_req_ready = 1'b1;  m_read_valid = 1'b1;  s_read_ready = 2'b11;
        hold_req[0] = 1'b1;
        s_req_valid = 2'b11;
        repeat (15) step();
        hold_req[0] = 1'b0;
        run_until_idle("t4", 30);
        check("t4_enough", 64'(gq.size() >= 4), 64'd1);
        check("t4_g0", 64'(gq.size() > 0 ? gq[0] : -1), 64'd0);
        check("t4_g1", 64'(gq.size() > 1 ? gq[1] : -1), 64'd1);
        check("t4_g2", 64'(gq.size() > 2 ? gq[2] : -1), 64'd0);
        check("t4_g3", 64'(gq.size() > 3 ? gq[3] : -1), 64'd0);

        // Burst with zero beats completes after one beat
        do_reset();
        s_req_rw[0] = 1'b1;  s_req_burst[0] = 1'b1;
        s_write_valid[0] = 1'b1;  s_write_data[0 +: DW] = 16'h0F0F;
        m_req_ready = 1'b1;  m_write_ready = 1'b1;
        s_req_valid[0] = 1'b1;
        repeat (3) step();
        check("t5_idle", 64'(busy_o), 64'd0);
        check("t5_wr_cnt", 64'(wr_cnt[0]), 64'd1);
        s_write_valid = '0;
        step();
        check("t5_no_extra", 64'(wr_cnt[0]), 64'd1);

        // Asynchronous reset during the second beat of a 4-beat read
        do_reset();
        s_req_burst[0] = 1'b1;  s_req_beats[0 +: BW] = 14'd4;
        m_req_ready = 1'b1;  m_read_valid = 1'b1;  s_read_ready = 2'b11;
        s_req_valid[0] = 1'b1;
        for (int k = 0; k < 20 && rd_cnt[0] < 1; k++) step();
        check("t6_first_beat", 64'(rd_cnt[0]), 64'd1);
        check("t6_in_burst", 64'(busy_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_grant", 64'(grant_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_rd_side", 64'({s_read_valid, m_read_ready}), 64'd0);
        check("t6_others", 64'({m_req_valid, m_write_valid, s_req_ready, s_write_ready}), 64'd0);
        idle_inputs();
        step();
        step();
        rst_i = 1'b0;
        clear_stats();
        s_req_rw[1] = 1'b1;  s_write_valid[1] = 1'b1;
        m_req_ready = 1'b1;  m_write_ready = 1'b1;
        s_req_valid[1] = 1'b1;
        step();
        check("t6_regrant", 64'(grant_o), 64'h2);
        run_until_idle("t6", 10);
        check("t6_wr_cnt", 64'(wr_cnt[1]), 64'd1);
        s_write_valid = '0;

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!s_req_valid[i] && $urandom_range(0, 3) == 0) begin
                    s_req_rw[i]             = 1'($urandom);
                    s_req_burst[i]          = 1'($urandom);
                    s_req_beats[i*BW +: BW] = BW'($urandom_range(0, 5));
                    s_req_addr[i*AW +: AW]  = $urandom;
                    s_req_valid[i]          = 1'b1;
                end
            end
            s_write_valid = N'($urandom);
            s_write_data  = (N*DW)'({$urandom, $urandom});
            s_write_strb  = (N*SW)'($urandom);
            s_read_ready  = N'($urandom);
            m_req_ready   = ($urandom_range(0, 3) != 0);
            m_write_ready = ($urandom_range(0, 3) != 0);
            m_read_valid  = ($urandom_range(0, 3) != 0);
            m_read_data   = DW'($urandom);
        end
        m_req_ready = 1'b1;  m_write_ready = 1'b1;  m_read_valid = 1'b1;
        s_write_valid = '1;  s_read_ready = '1;
        run_until_idle("rand_drain", 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
